// File: rtl/lsu_ctrl.sv
// Memory-stage load/store sequencer: issues one req/ack data-memory access per
// aligned load or store, stalls the pipeline until it completes, and formats load data.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  LoadSizeM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, ERR, DONE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] count, count_inc;
    logic          timeout;
    logic [1:0]    offset;
    logic [2:0]    load_size;
    logic          is_store, is_load, access, misaligned;
    logic [1:0]    size;
    logic [3:0]    be_new;
    logic [31:0]   wdata_new;
    logic [15:0]   lane;
    logic [31:0]   load_fmt;

    // size: 0 byte, 1 half, 2 word; a store takes precedence over a load
    always_comb begin
        is_store  = MemWriteM != 2'b00;
        is_load   = ResultSrcM == 2'b01;
        access    = is_store | is_load;
        if (is_store)
            size = MemWriteM - 2'b01;
        else
            size = (LoadSizeM[1:0] == 2'b11) ? 2'b10 : LoadSizeM[1:0];
        misaligned = access && ((size == 2'b01 && ALUResultM[0]) ||
                                (size == 2'b10 && ALUResultM[1:0] != 2'b00));
        be_new    = 4'b1111;
        wdata_new = 32'h0;
        if (is_store) begin
            wdata_new = WriteDataM;
            case (MemWriteM)
                2'b01: begin
                    be_new    = 4'b0001 << ALUResultM[1:0];
                    wdata_new = {4{WriteDataM[7:0]}};
                end
                2'b10: begin
                    be_new    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                    wdata_new = {2{WriteDataM[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        lane = 16'(dmem_rdata >> {offset, 3'b000});
        case (load_size)
            3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_fmt = {24'h0, lane[7:0]};
            3'b101:  load_fmt = {16'h0, lane[15:0]};
            default: load_fmt = dmem_rdata;
        endcase
    end

    // An ack on the last allowed REQ cycle still completes the access normally
    always_comb begin
        state_next = state;
        StallM     = 1'b0;
        MisalignM  = 1'b0;
        dmem_req   = 1'b0;
        BusErrM    = 1'b0;
        count_inc  = count + CW'(1);
        timeout    = count_inc == CW'(TIMEOUT_CYCLES);
        case (state)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        MisalignM = 1'b1;
                    end else begin
                        StallM     = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                StallM   = 1'b1;
                dmem_req = 1'b1;
                if (dmem_ack)
                    state_next = dmem_err ? ERR : DONE;
                else if (timeout)
                    state_next = ERR;
            end
            ERR: begin
                StallM     = 1'b1;
                BusErrM    = 1'b1;
                state_next = DONE;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            offset     <= 2'b00;
            load_size  <= 3'b000;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_be    <= 4'h0;
            dmem_wdata <= 32'h0;
            ReadDataM  <= 32'h0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (state_next == REQ) begin
                        count      <= '0;
                        dmem_addr  <= {ALUResultM[31:2], 2'b00};
                        dmem_we    <= is_store;
                        dmem_be    <= be_new;
                        dmem_wdata <= wdata_new;
                        offset     <= ALUResultM[1:0];
                        load_size  <= LoadSizeM;
                    end
                end
                REQ: begin
                    count <= count_inc;
                    if (state_next == DONE)
                        ReadDataM <= load_fmt;
                    else if (state_next == ERR)
                        ReadDataM <= 32'h0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a transaction-level model predicts bus fields and
// load results, and hand-computed vectors pin latency, formatting and error handling.
module tb_lsu_ctrl;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  MemWriteM = 2'b00;
    logic [1:0]  ResultSrcM = 2'b00;
    logic [2:0]  LoadSizeM = 3'b000;
    logic [31:0] ALUResultM = 32'h0;
    logic [31:0] WriteDataM = 32'h0;
    logic        StallM, MisalignM, BusErrM;
    logic [31:0] ReadDataM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        dmem_err = 1'b0;

    int checks = 0;
    int errors = 0;

    logic        model_active = 1'b0;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_we;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .LoadSizeM(LoadSizeM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .StallM(StallM), .ReadDataM(ReadDataM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [3:0] modelBe(input logic [1:0] memw, input logic [31:0] a);
        case (memw)
            2'd1:    return 4'(1 << a[1:0]);
            2'd2:    return a[1] ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] modelWdata(input logic [1:0] memw, input logic [31:0] d);
        case (memw)
            2'd1:    return {d[7:0], d[7:0], d[7:0], d[7:0]};
            2'd2:    return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] rd);
        logic [31:0] w;
        w = rd >> (8 * int'(a[1:0]));
        case (f3)
            3'b000:  return 32'(int'(w[7:0]) - (w[7] ? 256 : 0));
            3'b001:  return 32'(int'(w[15:0]) - (w[15] ? 65536 : 0));
            3'b100:  return 32'(w[7:0]);
            3'b101:  return 32'(w[15:0]);
            default: return rd;
        endcase
    endfunction

    // Bus fields must match the model on every REQ cycle; no request while nothing is pending
    always @(negedge clk) begin
        #2;
        if (reset_n) begin
            if (model_active && dmem_req) begin
                checkOutput("bus_addr", dmem_addr, exp_addr);
                checkOutput("bus_be", 32'(dmem_be), 32'(exp_be));
                checkOutput("bus_we", 32'(dmem_we), 32'(exp_we));
                if (exp_we)
                    checkOutput("bus_wdata", dmem_wdata, exp_wdata);
            end else if (!model_active) begin
                checkOutput("idle_no_req", 32'(dmem_req), 32'h0);
            end
        end
    end

    task automatic setModel(input logic [1:0] memw, input logic [31:0] addr, input logic [31:0] wd);
        exp_addr  = {addr[31:2], 2'b00};
        exp_we    = memw != 2'b00;
        exp_be    = modelBe(memw, addr);
        exp_wdata = modelWdata(memw, wd);
    endtask

    task automatic applyStimulus(input string name, input logic [1:0] memw, input logic [1:0] rsrc,
                                 input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rd, input int waits, input logic use_err,
                                 input int exp_stall, input int exp_req, input int exp_buserr,
                                 input logic check_rd, input logic [31:0] exp_rd);
        int  stall_cnt = 0;
        int  req_cnt = 0;
        int  err_cnt = 0;
        bit  done = 0;
        setModel(memw, addr, wd);
        MemWriteM = memw; ResultSrcM = rsrc; LoadSizeM = f3;
        ALUResultM = addr; WriteDataM = wd;
        model_active = 1'b1;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            #1;
            if (cyc == 0)
                checkOutput({name, "_misalign"}, 32'(MisalignM), 32'h0);
            dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = 32'hDEADBEEF;
            if (dmem_req) begin
                req_cnt++;
                if (req_cnt == waits + 1) begin
                    dmem_ack = 1'b1; dmem_rdata = rd; dmem_err = use_err;
                end
            end
            if (BusErrM) begin
                err_cnt++;
                checkOutput({name, "_err_rd"}, ReadDataM, 32'h0);
            end
            if (StallM) stall_cnt++;
            else done = 1;
            if (!done) @(negedge clk);
        end
        checkOutput({name, "_done"}, 32'(done), 32'h1);
        checkOutput({name, "_stall"}, 32'(stall_cnt), 32'(exp_stall));
        checkOutput({name, "_reqcyc"}, 32'(req_cnt), 32'(exp_req));
        checkOutput({name, "_buserr"}, 32'(err_cnt), 32'(exp_buserr));
        if (check_rd) begin
            checkOutput({name, "_rd"}, ReadDataM, exp_rd);
            if (exp_buserr == 0)
                checkOutput({name, "_rd_model"}, ReadDataM, modelLoad(f3, addr, rd));
        end
        MemWriteM = 2'b00; ResultSrcM = 2'b00;
        dmem_ack = 1'b0; dmem_err = 1'b0;
        model_active = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #3;
        checkOutput("rst_req", 32'(dmem_req), 32'h0);
        checkOutput("rst_addr", dmem_addr, 32'h0);
        checkOutput("rst_be", 32'(dmem_be), 32'h0);
        checkOutput("rst_rd", ReadDataM, 32'h0);
        checkOutput("rst_stall", 32'(StallM), 32'h0);
        checkOutput("rst_buserr", 32'(BusErrM), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        applyStimulus("sb", 2'b01, 2'b00, 3'b000, 32'h1003, 32'h000000A5, 32'h0, 0, 0, 2, 1, 0, 0, 32'h0);
        checkOutput("sb_be_lit", 32'(dmem_be), 32'h8);
        checkOutput("sb_wdata_lit", dmem_wdata, 32'hA5A5A5A5);
        checkOutput("sb_addr_lit", dmem_addr, 32'h1000);
        checkOutput("sb_we_lit", 32'(dmem_we), 32'h1);

        applyStimulus("lb", 2'b00, 2'b01, 3'b000, 32'h2001, 32'h0, 32'h00008000, 0, 0, 2, 1, 0, 1, 32'hFFFFFF80);
        applyStimulus("lbu", 2'b00, 2'b01, 3'b100, 32'h2001, 32'h0, 32'h00008000, 0, 0, 2, 1, 0, 1, 32'h00000080);
        applyStimulus("lhu", 2'b00, 2'b01, 3'b101, 32'h2002, 32'h0, 32'hBEEF0000, 0, 0, 2, 1, 0, 1, 32'h0000BEEF);
        applyStimulus("lh", 2'b00, 2'b01, 3'b001, 32'h2002, 32'h0, 32'hBEEF0000, 1, 0, 3, 2, 0, 1, 32'hFFFFBEEF);
        applyStimulus("sh", 2'b10, 2'b00, 3'b000, 32'h100A, 32'h1234ABCD, 32'h0, 0, 0, 2, 1, 0, 0, 32'h0);
        checkOutput("sh_be_lit", 32'(dmem_be), 32'hC);
        applyStimulus("sw_ld", 2'b11, 2'b01, 3'b010, 32'h1004, 32'hCAFEF00D, 32'h0, 0, 0, 2, 1, 0, 0, 32'h0);
        checkOutput("sw_we_lit", 32'(dmem_we), 32'h1);
        applyStimulus("lw_wait3", 2'b00, 2'b01, 3'b010, 32'h3000, 32'h0, 32'h0BADF00D, 3, 0, 5, 4, 0, 1, 32'h0BADF00D);

        MemWriteM = 2'b00; ResultSrcM = 2'b01; LoadSizeM = 3'b010; ALUResultM = 32'h1002;
        #1;
        checkOutput("lw_mis_flag", 32'(MisalignM), 32'h1);
        checkOutput("lw_mis_stall", 32'(StallM), 32'h0);
        repeat (3) @(negedge clk);
        MemWriteM = 2'b10; ResultSrcM = 2'b00; ALUResultM = 32'h1001;
        #1;
        checkOutput("sh_mis_flag", 32'(MisalignM), 32'h1);
        checkOutput("sh_mis_stall", 32'(StallM), 32'h0);
        repeat (3) @(negedge clk);
        MemWriteM = 2'b00;
        @(negedge clk);

        applyStimulus("timeout", 2'b00, 2'b01, 3'b010, 32'h4000, 32'h0, 32'h0, 100, 0, 6, 4, 1, 1, 32'h0);
        applyStimulus("lw_ok", 2'b00, 2'b01, 3'b010, 32'h4008, 32'h0, 32'h13579BDF, 0, 0, 2, 1, 0, 1, 32'h13579BDF);
        applyStimulus("ack_err", 2'b00, 2'b01, 3'b010, 32'h4004, 32'h0, 32'h77777777, 1, 1, 4, 2, 1, 1, 32'h0);
        applyStimulus("lbu_hi", 2'b00, 2'b01, 3'b100, 32'h6003, 32'h0, 32'hAB000000, 0, 0, 2, 1, 0, 1, 32'h000000AB);

        dmem_ack = 1'b1; dmem_err = 1'b1; dmem_rdata = 32'h99999999;
        @(negedge clk);
        #1;
        checkOutput("stray_ack_buserr", 32'(BusErrM), 32'h0);
        checkOutput("stray_ack_rd", ReadDataM, 32'h000000AB);
        dmem_ack = 1'b0; dmem_err = 1'b0;
        @(negedge clk);

        setModel(2'b00, 32'h5000, 32'h0);
        MemWriteM = 2'b00; ResultSrcM = 2'b01; LoadSizeM = 3'b010; ALUResultM = 32'h5000;
        model_active = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("pre_reset_req", 32'(dmem_req), 32'h1);
        reset_n = 1'b0;
        #1;
        checkOutput("reset_req", 32'(dmem_req), 32'h0);
        checkOutput("reset_addr", dmem_addr, 32'h0);
        checkOutput("reset_be", 32'(dmem_be), 32'h0);
        checkOutput("reset_we", 32'(dmem_we), 32'h0);
        checkOutput("reset_rd", ReadDataM, 32'h0);
        checkOutput("reset_buserr", 32'(BusErrM), 32'h0);
        checkOutput("reset_stall_idle", 32'(StallM), 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        MemWriteM = 2'b00; ResultSrcM = 2'b00;
        model_active = 1'b0;
        @(negedge clk);
        applyStimulus("post_reset", 2'b00, 2'b01, 3'b010, 32'h5000, 32'h0, 32'h55AA55AA, 0, 0, 2, 1, 0, 1, 32'h55AA55AA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
